// File: rtl/button_pio_debounced_pkg.sv
// Shared constants for the debounced button PIO: register word addresses and edge-capture modes.
package button_pio_debounced_pkg;

   localparam logic [1:0] ADDR_DATA    = 2'd0;
   localparam logic [1:0] ADDR_DIR     = 2'd1;
   localparam logic [1:0] ADDR_IRQMASK = 2'd2;
   localparam logic [1:0] ADDR_EDGECAP = 2'd3;

   localparam int EDGE_RISE = 0;
   localparam int EDGE_FALL = 1;
   localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/button_debounce_channel.sv
// One button input: multi-stage synchroniser followed by a counter that accepts a new
// level only after DEBOUNCE_CYCLES consecutive cycles of disagreement with the stable bit.
module button_debounce_channel
   import button_pio_debounced_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int IDLE_LEVEL      = 1
) (
   input  logic clk,
   input  logic reset_n,
   input  logic din,
   output logic stable
);

   localparam int             CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic           IDLE    = 1'(IDLE_LEVEL);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [CNT_W-1:0]       cnt;
   logic                   sync;

   assign sync = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= {SYNC_STAGES{IDLE}};
         cnt    <= '0;
         stable <= IDLE;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], din};
         if (sync == stable) begin
            cnt <= '0;
         end else if (cnt == CNT_MAX) begin
            // terminal count reached while still mismatched: accept the new level
            stable <= sync;
            cnt    <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/button_pio_debounced.sv
// Avalon-MM read-side PIO for debounced buttons with edge capture (write-1-to-clear),
// interrupt mask and level IRQ; readdata is registered with one cycle of latency.
module button_pio_debounced
   import button_pio_debounced_pkg::*;
#(
   parameter int WIDTH           = 4,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int SYNC_STAGES     = 2,
   parameter int EDGE_MODE       = 1,
   parameter int IDLE_LEVEL      = 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic             irq
);

   logic [WIDTH-1:0] stable;
   logic [WIDTH-1:0] stable_prev;
   logic [WIDTH-1:0] evt;
   logic [WIDTH-1:0] irqmask;
   logic [WIDTH-1:0] edgecap;
   logic [WIDTH-1:0] clr;
   logic [31:0]      rd_mux;
   logic             wr;
   logic             unused_wdata;

   assign unused_wdata = ^writedata;

   for (genvar i = 0; i < WIDTH; i++) begin : g_chan
      button_debounce_channel #(
         .SYNC_STAGES     (SYNC_STAGES),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .IDLE_LEVEL      (IDLE_LEVEL)
      ) u_chan (
         .clk     (clk),
         .reset_n (reset_n),
         .din     (in_port[i]),
         .stable  (stable[i])
      );
   end

   always_comb begin
      evt = '0;
      case (EDGE_MODE)
         EDGE_RISE: evt = stable & ~stable_prev;
         EDGE_FALL: evt = ~stable & stable_prev;
         default:   evt = stable ^ stable_prev;
      endcase
   end

   assign wr  = chipselect & ~write_n;
   assign clr = (wr && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;

   always_comb begin
      rd_mux = '0;
      case (address)
         ADDR_DATA:    rd_mux[WIDTH-1:0] = stable;
         ADDR_IRQMASK: rd_mux[WIDTH-1:0] = irqmask;
         ADDR_EDGECAP: rd_mux[WIDTH-1:0] = edgecap;
         default:      rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stable_prev <= {WIDTH{1'(IDLE_LEVEL)}};
         irqmask     <= '0;
         edgecap     <= '0;
         readdata    <= '0;
      end else begin
         stable_prev <= stable;
         if (wr && address == ADDR_IRQMASK)
            irqmask <= writedata[WIDTH-1:0];
         // a new event outranks a simultaneous clear so no press is lost
         edgecap  <= (edgecap & ~clr) | evt;
         readdata <= rd_mux;
      end
   end

   assign irq = |(edgecap & irqmask);

endmodule

// File: tb/tb_button_pio_debounced.sv
// Directed table-driven bench for button_pio_debounced (WIDTH=4, DEBOUNCE_CYCLES=4, falling-edge capture).
module tb_button_pio_debounced;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [3:0]  in_port;
   logic        irq;

   int n_tests = 0;
   int n_fail  = 0;

   button_pio_debounced #(
      .WIDTH           (4),
      .DEBOUNCE_CYCLES (4),
      .SYNC_STAGES     (2),
      .EDGE_MODE       (1),
      .IDLE_LEVEL      (1)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .in_port    (in_port),
      .irq        (irq)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        wr;
      logic [1:0]  addr;
      logic [31:0] wdata;
      logic [3:0]  inp;
      int          hold;
      logic [31:0] exp_rd;
      logic        exp_irq;
   } vec_t;

   vec_t vecs[20];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   initial begin
      //            wr    addr   wdata          in    hold exp_rd         irq
      vecs[0]  = '{1'b0, 2'd0, 32'h0,        4'hF, 1, 32'h0000000F, 1'b0}; // reset data
      vecs[1]  = '{1'b0, 2'd1, 32'h0,        4'hF, 1, 32'h00000000, 1'b0}; // direction
      vecs[2]  = '{1'b0, 2'd3, 32'h0,        4'hF, 1, 32'h00000000, 1'b0}; // edgecap after reset
      vecs[3]  = '{1'b0, 2'd2, 32'h0,        4'hF, 1, 32'h00000000, 1'b0}; // irqmask after reset
      vecs[4]  = '{1'b0, 2'd0, 32'h0,        4'hE, 6, 32'h0000000F, 1'b0}; // one cycle before accept
      vecs[5]  = '{1'b0, 2'd0, 32'h0,        4'hE, 1, 32'h0000000E, 1'b0}; // accepted at 2+4
      vecs[6]  = '{1'b0, 2'd3, 32'h0,        4'hE, 1, 32'h00000001, 1'b0}; // falling edge captured
      vecs[7]  = '{1'b0, 2'd0, 32'h0,        4'hF, 8, 32'h0000000F, 1'b0}; // release
      vecs[8]  = '{1'b0, 2'd3, 32'h0,        4'hF, 1, 32'h00000001, 1'b0}; // rising not captured
      vecs[9]  = '{1'b1, 2'd3, 32'h1,        4'hF, 2, 32'h00000000, 1'b0}; // W1C
      vecs[10] = '{1'b0, 2'd0, 32'h0,        4'hE, 3, 32'h0000000F, 1'b0}; // 3-cycle glitch
      vecs[11] = '{1'b0, 2'd3, 32'h0,        4'hF, 8, 32'h00000000, 1'b0}; // glitch not captured
      vecs[12] = '{1'b0, 2'd0, 32'h0,        4'hF, 1, 32'h0000000F, 1'b0};
      vecs[13] = '{1'b0, 2'd0, 32'h0,        4'hE, 4, 32'h0000000F, 1'b0}; // 4-cycle pulse
      vecs[14] = '{1'b0, 2'd3, 32'h0,        4'hF, 8, 32'h00000001, 1'b0}; // pulse captured
      vecs[15] = '{1'b1, 2'd2, 32'h1,        4'hF, 1, 32'h00000000, 1'b1}; // mask on -> irq
      vecs[16] = '{1'b0, 2'd3, 32'h0,        4'hF, 1, 32'h00000001, 1'b1};
      vecs[17] = '{1'b1, 2'd3, 32'h1,        4'hF, 1, 32'h00000001, 1'b0}; // clear -> irq low
      vecs[18] = '{1'b1, 2'd2, 32'hFFFFFFFF, 4'hF, 2, 32'h0000000F, 1'b0}; // mask upper bits dropped
      vecs[19] = '{1'b0, 2'd0, 32'h0,        4'hF, 1, 32'h0000000F, 1'b0};

      reset_n    = 1'b1;
      address    = 2'd0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = 32'h0;
      in_port    = 4'hF;
      #2 reset_n = 1'b0;
      #1;
      chk("reset_readdata", readdata, 32'h0);
      chk("reset_irq", {31'h0, irq}, 32'h0);
      #19 reset_n = 1'b1;

      for (int i = 0; i < 20; i++) begin
         in_port    = vecs[i].inp;
         address    = vecs[i].addr;
         chipselect = vecs[i].wr;
         write_n    = ~vecs[i].wr;
         writedata  = vecs[i].wdata;
         tick();
         chipselect = 1'b0;
         write_n    = 1'b1;
         for (int k = 1; k < vecs[i].hold; k++) tick();
         chk($sformatf("vec%0d_readdata", i), readdata, vecs[i].exp_rd);
         chk($sformatf("vec%0d_irq", i), {31'h0, irq}, {31'h0, vecs[i].exp_irq});
      end

      // event lands in the same cycle as a W1C of the same bit: set must win
      in_port = 4'hE;
      address = 2'd3;
      for (int k = 0; k < 6; k++) tick();
      chipselect = 1'b1;
      write_n    = 1'b0;
      writedata  = 32'h1;
      tick();
      chipselect = 1'b0;
      write_n    = 1'b1;
      chk("coincide_irq", {31'h0, irq}, 32'h1);
      tick();
      chk("coincide_edgecap", readdata, 32'h1);

      in_port = 4'hF;
      for (int k = 0; k < 8; k++) tick();
      chk("irq_held", {31'h0, irq}, 32'h1);

      // bit2 mid-count (counter=2) when reset hits between clock edges
      in_port = 4'hB;
      address = 2'd0;
      for (int k = 0; k < 4; k++) tick();
      chk("precut_data", readdata, 32'h0000000F);
      #2 reset_n = 1'b0;
      #1;
      chk("midreset_readdata", readdata, 32'h0);
      chk("midreset_irq", {31'h0, irq}, 32'h0);
      #1 reset_n = 1'b1;
      for (int k = 0; k < 6; k++) tick();
      chk("postreset_no_early", readdata, 32'h0000000F);
      tick();
      chk("postreset_full_count", readdata, 32'h0000000B);
      address = 2'd3;
      tick();
      chk("postreset_edgecap", readdata, 32'h00000004);
      chk("postreset_irq", {31'h0, irq}, 32'h0);
      address = 2'd2;
      tick();
      chk("postreset_mask", readdata, 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/button_pio_debounced.md
Name: button_pio_debounced

Overview:
Parametrised Avalon-MM read-side PIO for push-buttons/switches, the successor of the team's fixed 4-bit button input port. Adds per-channel input synchronisation, counter-based debounce, configurable edge capture with write-1-to-clear, an interrupt mask and a level IRQ. It sits on the system interconnect as a slave next to the timer/clock peripherals and feeds the CPU the debounced button state and button-press events.

Parameters:
WIDTH, 4, number of input channels (1..32)
DEBOUNCE_CYCLES, 500000, consecutive stable cycles required before a change is accepted (10 ms at 50 MHz); minimum 1
SYNC_STAGES, 2, flip-flop stages in the input synchroniser (minimum 2)
EDGE_MODE, 1, 0 = capture rising edges, 1 = falling, 2 = any edge, on the debounced signal
IDLE_LEVEL, 1, reset value of every synchroniser and debounced bit (1 = active-low keys idle high)

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
address  input  2  Avalon word address
chipselect  input  1  slave select
write_n  input  1  active-low write strobe
writedata  input  32  write data
readdata  output  32  registered read data
in_port  input  WIDTH  raw asynchronous button inputs
irq  output  1  level interrupt request, active high

Behaviour:
- Reset: reset_n is asynchronous, active-low; clock is clk. All state is cleared on reset assertion regardless of clk: readdata=0, irq=0, irqmask=0, edgecapture=0, debounce counters=0, synchroniser and debounced bits = IDLE_LEVEL (replicated across WIDTH).
- Synchroniser: each in_port bit passes through SYNC_STAGES flops; sync[i] is the last stage.
- Debounce, per channel: counter width = clog2(DEBOUNCE_CYCLES) (min 1).
  - If sync[i]==stable[i]: counter cleared.
  - Else if counter==DEBOUNCE_CYCLES-1: stable[i]<=sync[i], counter cleared.
  - Else counter+1.
  - Net effect: stable changes exactly on the DEBOUNCE_CYCLES-th consecutive cycle of sync mismatch; any glitch shorter than that is discarded with no effect. Counter never wraps.
- Edge detect: event[i] asserted for one cycle in the cycle stable[i] changes, qualified by EDGE_MODE (0: 0->1, 1: 1->0, 2: either).
- edgecapture[i]: set on event[i]; cleared by a write to address 3 with writedata[i]=1. If set and clear coincide in the same cycle, set wins (no event is lost).
- irq = OR(edgecapture & irqmask), driven from registers, so it is high the cycle after the capture bit sets and low the cycle after the clearing write.
- Register map (word addresses); write = chipselect & ~write_n:
  - 0 data: R = stable, zero-extended; writes ignored.
  - 1 direction: R = 0; writes ignored.
  - 2 irqmask: R/W, bits [WIDTH-1:0] only; upper write bits ignored.
  - 3 edgecapture: R; write-1-to-clear.
- Read: readdata is updated every clock with the mux output for the current address (1-cycle read latency); chipselect is not needed for reads. The read has no side effects.
- Bits above WIDTH always read 0.
- Reset mid-debounce: the partial count is discarded and no event is generated.

Decomposition:
- Shared package: register address constants (ADDR_DATA=0, ADDR_DIR=1, ADDR_IRQMASK=2, ADDR_EDGECAP=3) and EDGE_MODE encodings (EDGE_RISE, EDGE_FALL, EDGE_ANY).
- One sub-module, button_debounce_channel: synchroniser, counter and stable bit for one input, parametrised by SYNC_STAGES, DEBOUNCE_CYCLES and IDLE_LEVEL. The top generates WIDTH instances and owns edge detect, registers and bus logic.

Test Plan (DEBOUNCE_CYCLES=4, SYNC_STAGES=2, EDGE_MODE=1, WIDTH=4, IDLE_LEVEL=1):
- Reset, then read address 0 -> readdata=0x0000000F one cycle later; address 1 -> 0; irq=0; address 3 -> 0.
- Drive in_port=0xE (bit0 pressed) and hold -> stable bit0 falls exactly 2+4 cycles after the change; address 3 reads 0x1; address 0 reads 0xE.
- Pulse in_port bit0 low for 3 cycles, then return high -> no change to stable or edgecapture; a 4-cycle pulse does set edgecapture.
- Write irqmask=0x1 with edgecapture=0x1 -> irq=1 the cycle after the write. Write 0x1 to address 3 -> edgecapture=0 and irq=0 the cycle after the write. Write 0xFFFFFFFF to address 2 -> address 2 reads 0x0000000F.
- Schedule a bit0 event in the same cycle as a W1C write of 0x1 to address 3 -> edgecapture bit0 remains 1 and irq stays high.
- Assert reset_n low while bit2 is mid-count (counter=2), without a clock edge -> all outputs reset immediately; after release, bit2 needs a full 4 mismatch cycles and no spurious event occurs.
